// File: rtl/player_death_ctrl_if.sv
// Handshake bundle between the lives/input stages and the player death controller.
// The master side drives frame ticks, lives and keys; the slave side returns player status.
`timescale 1ns/1ps

interface player_death_ctrl_if;
  logic       startOfFrame;
  logic [3:0] lives;
  logic       player_died;
  logic       restart_key;
  logic       player_visible;
  logic       player_frozen;
  logic       invulnerable;
  logic       respawn_pulse;
  logic       game_over;
  logic [1:0] state_dbg;

  modport master (
    output startOfFrame,
    output lives,
    output player_died,
    output restart_key,
    input  player_visible,
    input  player_frozen,
    input  invulnerable,
    input  respawn_pulse,
    input  game_over,
    input  state_dbg
  );

  modport slave (
    input  startOfFrame,
    input  lives,
    input  player_died,
    input  restart_key,
    output player_visible,
    output player_frozen,
    output invulnerable,
    output respawn_pulse,
    output game_over,
    output state_dbg
  );
endinterface

// File: rtl/player_death_ctrl.sv
// Player life-cycle controller: ALIVE -> DYING (blinking, frozen) -> INVULN (blinking) or GAME_OVER.
// All outputs are registered and equal a decode of the registered state and blink phase.
`timescale 1ns/1ps

module player_death_ctrl #(
  parameter int unsigned DEATH_FRAMES  = 60,
  parameter int unsigned INVULN_FRAMES = 120,
  parameter int unsigned BLINK_PERIOD  = 8
) (
  input  logic               clk,
  input  logic               resetN,
  player_death_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_ALIVE     = 2'd0,
    ST_DYING     = 2'd1,
    ST_INVULN    = 2'd2,
    ST_GAME_OVER = 2'd3
  } state_t;

  localparam logic [7:0] DEATH_LAST  = 8'(DEATH_FRAMES - 1);
  localparam logic [7:0] INVULN_LAST = 8'(INVULN_FRAMES - 1);
  localparam logic [7:0] BLINK_LAST  = 8'(BLINK_PERIOD - 1);
  localparam logic [3:0] LIVES_RESET = 4'd3;

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_lives_prev;
  logic       r_restart_key;
  logic [7:0] r_frame_cnt;
  logic [7:0] r_blink_cnt;
  logic       r_blink_phase;
  logic [7:0] w_frame_cnt_next;
  logic [7:0] w_blink_cnt_next;
  logic       w_blink_phase_next;

  logic       r_player_visible;
  logic       r_player_frozen;
  logic       r_invulnerable;
  logic       r_respawn_pulse;
  logic       r_game_over;
  logic [1:0] r_state_dbg;

  logic       w_visible_next;
  logic       w_frozen_next;
  logic       w_invuln_next;
  logic       w_game_over_next;
  logic       w_respawn_next;

  logic       w_life_lost;
  logic       w_restart_edge;
  logic       w_counting;
  logic       w_death_done;
  logic       w_invuln_done;

  assign w_life_lost    = (bus.lives < r_lives_prev);
  assign w_restart_edge = bus.restart_key & ~r_restart_key;
  assign w_counting     = (r_state == ST_DYING) || (r_state == ST_INVULN);
  assign w_death_done   = bus.startOfFrame && (r_frame_cnt == DEATH_LAST);
  assign w_invuln_done  = bus.startOfFrame && (r_frame_cnt == INVULN_LAST);

  // End-of-count exits are tested before hit handling so they win a same-clk collision.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_ALIVE: begin
        if (w_life_lost || bus.player_died) begin
          w_state_next = ST_DYING;
        end
      end
      ST_DYING: begin
        if (w_death_done) begin
          w_state_next = bus.player_died ? ST_GAME_OVER : ST_INVULN;
        end
      end
      ST_INVULN: begin
        if (w_invuln_done) begin
          w_state_next = ST_ALIVE;
        end else if (bus.player_died) begin
          w_state_next = ST_DYING;
        end
      end
      ST_GAME_OVER: begin
        if (w_restart_edge && !bus.player_died) begin
          w_state_next = ST_ALIVE;
        end
      end
      default: w_state_next = ST_ALIVE;
    endcase
  end

  assign w_respawn_next = (r_state == ST_DYING) && (w_state_next == ST_INVULN);

  // Counters restart on every state entry; INVULN starts with the sprite shown.
  always_comb begin
    w_frame_cnt_next   = r_frame_cnt;
    w_blink_cnt_next   = r_blink_cnt;
    w_blink_phase_next = r_blink_phase;
    if (w_state_next != r_state) begin
      w_frame_cnt_next   = 8'd0;
      w_blink_cnt_next   = 8'd0;
      w_blink_phase_next = (w_state_next == ST_INVULN);
    end else if (w_counting && bus.startOfFrame) begin
      w_frame_cnt_next = (r_frame_cnt == 8'hFF) ? 8'hFF : r_frame_cnt + 8'd1;
      if (r_blink_cnt == BLINK_LAST) begin
        w_blink_cnt_next   = 8'd0;
        w_blink_phase_next = ~r_blink_phase;
      end else begin
        w_blink_cnt_next = r_blink_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    w_visible_next   = 1'b1;
    w_frozen_next    = 1'b0;
    w_invuln_next    = 1'b0;
    w_game_over_next = 1'b0;
    case (w_state_next)
      ST_ALIVE: begin
        w_visible_next = 1'b1;
      end
      ST_DYING: begin
        w_visible_next = w_blink_phase_next;
        w_frozen_next  = 1'b1;
        w_invuln_next  = 1'b1;
      end
      ST_INVULN: begin
        w_visible_next = w_blink_phase_next;
        w_invuln_next  = 1'b1;
      end
      ST_GAME_OVER: begin
        w_visible_next   = 1'b0;
        w_frozen_next    = 1'b1;
        w_invuln_next    = 1'b1;
        w_game_over_next = 1'b1;
      end
      default: begin
        w_visible_next = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state          <= ST_ALIVE;
      r_lives_prev     <= LIVES_RESET;
      r_restart_key    <= 1'b0;
      r_frame_cnt      <= 8'd0;
      r_blink_cnt      <= 8'd0;
      r_blink_phase    <= 1'b0;
      r_player_visible <= 1'b1;
      r_player_frozen  <= 1'b0;
      r_invulnerable   <= 1'b0;
      r_respawn_pulse  <= 1'b0;
      r_game_over      <= 1'b0;
      r_state_dbg      <= 2'd0;
    end else begin
      r_state          <= w_state_next;
      r_lives_prev     <= bus.lives;
      r_restart_key    <= bus.restart_key;
      r_frame_cnt      <= w_frame_cnt_next;
      r_blink_cnt      <= w_blink_cnt_next;
      r_blink_phase    <= w_blink_phase_next;
      r_player_visible <= w_visible_next;
      r_player_frozen  <= w_frozen_next;
      r_invulnerable   <= w_invuln_next;
      r_respawn_pulse  <= w_respawn_next;
      r_game_over      <= w_game_over_next;
      r_state_dbg      <= w_state_next;
    end
  end

  assign bus.player_visible = r_player_visible;
  assign bus.player_frozen  = r_player_frozen;
  assign bus.invulnerable   = r_invulnerable;
  assign bus.respawn_pulse  = r_respawn_pulse;
  assign bus.game_over      = r_game_over;
  assign bus.state_dbg      = r_state_dbg;

endmodule

// File: tb/tb_player_death_ctrl.sv
// Scoreboard bench: stimulus queues every expected output change with its frame distance,
// a negedge monitor pops and compares whenever the output vector changes.
`timescale 1ns/1ps

module tb_player_death_ctrl;

  localparam logic [1:0] S_AL = 2'd0;
  localparam logic [1:0] S_DY = 2'd1;
  localparam logic [1:0] S_IN = 2'd2;
  localparam logic [1:0] S_GO = 2'd3;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  player_death_ctrl_if bus();

  player_death_ctrl #(
    .DEATH_FRAMES (60),
    .INVULN_FRAMES(120),
    .BLINK_PERIOD (8)
  ) dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (bus)
  );

  logic [6:0] q_vec[$];
  int         q_cnt[$];
  int         q_tag[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         tag_id  = 0;
  bit         mon_en  = 1'b0;
  bit         end_req = 1'b0;
  bit         end_done = 1'b0;

  // Expected vector {visible, frozen, invulnerable, respawn, game_over, state[1:0]}
  function automatic logic [6:0] ev(logic [1:0] st, logic vis, logic rsp);
    logic v, frz, inv, go;
    case (st)
      S_AL:    {v, frz, inv, go} = {1'b1, 1'b0, 1'b0, 1'b0};
      S_DY:    {v, frz, inv, go} = {vis,  1'b1, 1'b1, 1'b0};
      S_IN:    {v, frz, inv, go} = {vis,  1'b0, 1'b1, 1'b0};
      default: {v, frz, inv, go} = {1'b0, 1'b1, 1'b1, 1'b1};
    endcase
    return {v, frz, inv, rsp, go, st};
  endfunction

  task automatic push(input logic [6:0] v, input int c);
    q_vec.push_back(v);
    q_cnt.push_back(c);
    q_tag.push_back(tag_id);
    tag_id++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      bus.startOfFrame = 1'b1;
      tick();
      bus.startOfFrame = 1'b0;
      repeat (3) tick();
    end
  endtask

  // 60-frame death: 7 blink toggles every 8 frames, exit 4 frames later with a one-clk respawn.
  task automatic push_dying_to_invuln();
    for (int k = 1; k <= 7; k++) push(ev(S_DY, (k % 2) == 1, 1'b0), 8);
    push(ev(S_IN, 1'b1, 1'b1), 4);
    push(ev(S_IN, 1'b1, 1'b0), 0);
  endtask

  // 120-frame invulnerability starting visible: 14 toggles, back to ALIVE 8 frames after the last.
  task automatic push_invuln_full();
    for (int k = 1; k <= 14; k++) push(ev(S_IN, (k % 2) == 0, 1'b0), 8);
    push(ev(S_AL, 1'b1, 1'b0), 8);
  endtask

  logic [6:0] cur_vec;
  logic [6:0] prev_vec;
  logic [6:0] exp_vec;
  int         exp_cnt;
  int         exp_tag;
  bit         first_ev = 1'b1;
  int         sof_cnt = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      cur_vec = {bus.player_visible, bus.player_frozen, bus.invulnerable,
                 bus.respawn_pulse, bus.game_over, bus.state_dbg};
      if (first_ev || (cur_vec != prev_vec)) begin
        if (q_vec.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_event actual=%b after %0d frames required=no change", cur_vec, sof_cnt);
        end else begin
          exp_vec = q_vec.pop_front();
          exp_cnt = q_cnt.pop_front();
          exp_tag = q_tag.pop_front();
          n_tests++;
          if (cur_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL ev%0d_outputs actual=%b required=%b", exp_tag, cur_vec, exp_vec);
          end else begin
            $display("[TB] ev%0d outputs=%b frames=%0d", exp_tag, cur_vec, sof_cnt);
          end
          n_tests++;
          if (sof_cnt != exp_cnt) begin
            n_fail++;
            $display("FAIL ev%0d_frames actual=%0d required=%0d", exp_tag, sof_cnt, exp_cnt);
          end
        end
        prev_vec = cur_vec;
        first_ev = 1'b0;
        sof_cnt  = 0;
      end
      if (bus.startOfFrame) sof_cnt++;
      if (end_req && !end_done) begin
        n_tests++;
        if (q_vec.size() != 0) begin
          n_fail++;
          $display("FAIL pending_events actual=%0d required=0", q_vec.size());
        end
        end_done = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.startOfFrame = 1'b0;
    bus.lives        = 4'd3;
    bus.player_died  = 1'b0;
    bus.restart_key  = 1'b0;

    // Reset values
    push(ev(S_AL, 1'b1, 1'b0), 0);
    repeat (2) tick();
    mon_en = 1'b1;
    repeat (3) tick();
    resetN = 1'b1;
    repeat (4) tick();

    // Life loss 3->2 in ALIVE: full death and invulnerability cycle
    push(ev(S_DY, 1'b0, 1'b0), 0);
    push_dying_to_invuln();
    push_invuln_full();
    bus.lives = 4'd2;
    tick();
    frames(60);
    frames(120);
    repeat (4) tick();

    // Lives increase 2->3 in ALIVE: no output change
    bus.lives = 4'd3;
    repeat (6) tick();

    // Loss 3->2, then 2->1 during INVULN is ignored and the count runs on
    push(ev(S_DY, 1'b0, 1'b0), 0);
    push_dying_to_invuln();
    push_invuln_full();
    bus.lives = 4'd2;
    tick();
    frames(60);
    frames(20);
    bus.lives = 4'd1;
    frames(100);
    repeat (4) tick();

    // Last life 1->0 from ALIVE: 60 frames of DYING then GAME_OVER, no respawn
    push(ev(S_DY, 1'b0, 1'b0), 0);
    for (int k = 1; k <= 7; k++) push(ev(S_DY, (k % 2) == 1, 1'b0), 8);
    push(ev(S_GO, 1'b0, 1'b0), 4);
    bus.lives       = 4'd0;
    bus.player_died = 1'b1;
    tick();
    frames(60);
    frames(10);

    // Restart while still dead is ignored; then lives restored and a key edge restarts
    bus.restart_key = 1'b1;
    repeat (3) tick();
    bus.restart_key = 1'b0;
    repeat (3) tick();
    bus.lives       = 4'd3;
    bus.player_died = 1'b0;
    repeat (3) tick();
    push(ev(S_AL, 1'b1, 1'b0), 10);
    bus.restart_key = 1'b1;
    repeat (3) tick();
    bus.restart_key = 1'b0;
    repeat (3) tick();

    // Fatal hit during INVULN forces DYING next clk; reset at frame 30 of that DYING
    push(ev(S_DY, 1'b0, 1'b0), 0);
    push_dying_to_invuln();
    push(ev(S_IN, 1'b0, 1'b0), 8);
    push(ev(S_DY, 1'b0, 1'b0), 2);
    push(ev(S_DY, 1'b1, 1'b0), 8);
    push(ev(S_DY, 1'b0, 1'b0), 8);
    push(ev(S_DY, 1'b1, 1'b0), 8);
    push(ev(S_AL, 1'b1, 1'b0), 6);
    bus.lives = 4'd2;
    tick();
    frames(60);
    frames(5);
    bus.lives = 4'd1;
    frames(5);
    bus.lives       = 4'd0;
    bus.player_died = 1'b1;
    tick();
    frames(30);
    resetN          = 1'b0;
    bus.lives       = 4'd3;
    bus.player_died = 1'b0;
    repeat (3) tick();
    resetN = 1'b1;
    repeat (20) tick();

    end_req = 1'b1;
    repeat (3) tick();
    if (!end_done) begin
      n_tests++;
      n_fail++;
      $display("FAIL end_check actual=not_done required=done");
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/player_death_ctrl.md
PLAYER_DEATH_CTRL -- requirements
Module: player_death_ctrl

Interface
REQ-001 Parameter DEATH_FRAMES, default 60: number of frame ticks spent in the DYING state.
REQ-002 Parameter INVULN_FRAMES, default 120: number of frame ticks spent in the INVULN state after a respawn.
REQ-003 Parameter BLINK_PERIOD, default 8: number of frame ticks per player_visible toggle while blinking; legal range 1..255.
REQ-004 Port clk  input  1  the single system clock; every register in the block is clocked on its rising edge.
REQ-005 Port resetN  input  1  asynchronous active-low reset.
REQ-006 Port startOfFrame  input  1  one-clk pulse per video frame; this is the frame tick.
REQ-007 Port lives  input  4  current life count from the lives counter stage.
REQ-008 Port player_died  input  1  level signal from the lives counter stage; high while lives==0.
REQ-009 Port restart_key  input  1  level input from the player's restart key.
REQ-010 Port player_visible  output  1  player sprite enable.
REQ-011 Port player_frozen  output  1  blocks player movement and bomb placement.
REQ-012 Port invulnerable  output  1  tells the collision logic to ignore hits on the player.
REQ-013 Port respawn_pulse  output  1  one-clk pulse; commands the player position block to reload the start tile.
REQ-014 Port game_over  output  1  selects the game-over screen.
REQ-015 Port state_dbg  output  2  current FSM state encoding: ALIVE=0, DYING=1, INVULN=2, GAME_OVER=3.

Function
REQ-016 The block SHALL register lives into lives_prev every clk and SHALL flag life_lost when lives < lives_prev.
- A lives increase updates lives_prev only; it causes no other action.
REQ-017 The block SHALL register restart_key and SHALL detect its 0->1 edge as restart_edge.
REQ-018 The frame counter SHALL be 8 bits wide.
- Cleared on every state entry.
- Increments only on startOfFrame.
- Saturates at 255.
REQ-019 The blink counter SHALL be 8 bits wide.
- Cleared on every state entry.
- Increments on startOfFrame.
- On reaching BLINK_PERIOD-1 with startOfFrame high, it wraps to 0 and the blink phase toggles.
REQ-020 In ALIVE the block SHALL drive visible=1, frozen=0, invulnerable=0 and game_over=0.
- life_lost or player_died moves the FSM to DYING on the next clk.
REQ-021 In DYING the block SHALL drive frozen=1, invulnerable=1, game_over=0, and player_visible = blink phase.
- The blink phase is 0 on entry.
- The FSM leaves DYING on the startOfFrame that brings the frame counter to DEATH_FRAMES.
- Leaving with player_died=1 goes to GAME_OVER.
- Leaving with player_died=0 goes to INVULN, and respawn_pulse is high for exactly that one transition clk.
REQ-022 In INVULN the block SHALL drive frozen=0, invulnerable=1, game_over=0, and player_visible = blink phase.
- The blink phase is 1 on entry.
- The FSM returns to ALIVE on the startOfFrame that brings the frame counter to INVULN_FRAMES.
REQ-023 In INVULN, life_lost with player_died=0 SHALL be ignored; player_died=1 SHALL force DYING on the next clk.
REQ-024 In GAME_OVER the block SHALL drive visible=0, frozen=1, invulnerable=1 and game_over=1.
- restart_edge with player_died=0 returns the FSM to ALIVE.
- restart_edge with player_died=1 is ignored.
REQ-025 When life_lost and the end-of-count condition occur in the same clk, the state-exit transition SHALL take priority.
- One exception: life_lost in ALIVE always wins, because ALIVE has no count.
REQ-026 Outputs SHALL be decoded from registered state plus the registered blink phase only.
- respawn_pulse is a registered one-clk pulse.
REQ-027 respawn_pulse SHALL never be asserted in two consecutive clks.
REQ-028 startOfFrame SHALL have no effect in ALIVE or GAME_OVER apart from being ignored.

Reset
REQ-029 While resetN=0 the block SHALL asynchronously force the following values:
- state=ALIVE, lives_prev=4'd3, both counters=0, blink phase=0, restart_key register=0.
- player_visible=1, player_frozen=0, invulnerable=0, respawn_pulse=0, game_over=0, state_dbg=0.
REQ-030 Reset asserted mid-DYING or mid-INVULN SHALL abort the sequence with no respawn_pulse.
- After resetN deasserts, the block resumes in ALIVE.

Verification
REQ-031 Life loss: with lives 3->2 in ALIVE, the bench SHALL check the following:
- state_dbg=1 one clk later, frozen=1, and visible toggles every 8 frames.
- After 60 frames: one respawn_pulse, state_dbg=2.
- After 120 more frames: state_dbg=0, invulnerable=0.
REQ-032 Last life: with lives 1->0 and player_died=1, the bench SHALL check that DYING lasts 60 frames, then state_dbg=3, game_over=1, visible=0, and that no respawn_pulse occurs.
REQ-033 Hit during invulnerability: the bench SHALL check both cases.
- lives 2->1 in INVULN: state is unchanged and the INVULN count continues.
- lives 1->0 with player_died=1 in INVULN: state_dbg=1 on the next clk.
REQ-034 Restart: the bench SHALL check both cases in GAME_OVER.
- restart_key pulse while player_died=1: no change.
- Lives raised to 3 by upstream, then a restart_key rising edge: state_dbg=0 one clk later and game_over=0.
REQ-035 Reset mid-operation: the bench SHALL check both cases.
- resetN low at frame 30 of DYING: all outputs take their reset values immediately, with no respawn_pulse.
- A lives increase 2->3 in ALIVE: no state change.
